// File: rtl/mult_sched_if.sv
// Handshake bundle between two requesters, one result consumer and the shared multiplier.
// master = requester/consumer side, slave = mult_sched.
interface mult_sched_if #(parameter int W = 4);
    logic           req0_valid;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           req1_ready;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_p;
    logic           res_id;
    logic           busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_p, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_p, res_id, busy
    );
endinterface

// File: rtl/mult_sched.sv
// Two-requester scheduler around one shift-add multiplier (IDLE/BUSY/DONE).
// Optional macro MULT_SCHED_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier is zero.
module mult_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    mult_sched_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } opnd_t;

    state_t              state;
    logic [2*W-1:0]      mcand;
    logic [W-1:0]        mplier;
    logic [2*W-1:0]      acc;
    logic [2*W-1:0]      res_p_q;
    logic [CW-1:0]       cnt;
    logic                id_q;
    logic                last_grant;

    logic [1:0]          req_valid;
    logic [1:0][W-1:0]   req_a;
    logic [1:0][W-1:0]   req_b;
    logic                grant_id;
    logic                accept;
    opnd_t               sel;
    logic [2*W-1:0]      acc_nxt;
    logic [W-1:0]        mplier_nxt;
    logic                last_iter;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a     = {bus.req1_a, bus.req0_a};
    assign req_b     = {bus.req1_b, bus.req0_b};

    // On a tie the requester that did not win last time gets the engine.
    assign grant_id = (&req_valid) ? ~last_grant : req_valid[1];
    assign accept   = (state == IDLE) && !rst && (|req_valid);
    assign sel      = '{a: req_a[grant_id], b: req_b[grant_id]};

    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;

    assign acc_nxt    = mplier[0] ? acc + mcand : acc;
    assign mplier_nxt = mplier >> 1;

`ifdef MULT_SCHED_EARLY_TERM_EN
    assign last_iter = (cnt == CW'(W - 1)) || (mplier_nxt == '0);
`else
    assign last_iter = (cnt == CW'(W - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            res_p_q    <= '0;
            cnt        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        mcand      <= {{W{1'b0}}, sel.a};
                        mplier     <= sel.b;
                        acc        <= '0;
                        cnt        <= '0;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        res_p_q <= acc_nxt;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status is forced low for the whole reset cycle, not only after the edge.
    assign bus.res_valid = (state == DONE) && !rst;
    assign bus.busy      = (state != IDLE) && !rst;
    assign bus.res_p     = res_p_q;
    assign bus.res_id    = id_q;
endmodule
